iic_slave: RTL
==============

# iic_slave

I2C target (slave) for the on-chip register file. It answers the writes produced by the team's I2C master: device address, word address, then data. It also supports random and sequential reads. It oversamples the bus on sys_clk, decodes START, STOP, address and data, ACKs on the bus, and presents a simple one-cycle write strobe and prefetch read port to the register file.

## Interface

Parameters:
- DEV_ADDR, 7'h50: 7-bit device address matched against address byte bits [7:1].
- GLITCH_CYC, 3: consecutive identical samples required before a filtered line changes.

Ports (reset is rst_n, asynchronous, active-low; clock is sys_clk):
- sys_clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- scl  input  1  I2C clock from master
- sda  inout  1  I2C data; open-drain, driven only 0 or Z
- wr_en  output  1  one-cycle write strobe
- wr_addr  output  8  write word address
- wr_data  output  8  write data byte
- rd_req  output  1  one-cycle read request
- rd_addr  output  8  read word address
- rd_data  input  8  read data, valid 1 cycle after rd_req
- busy  output  1  high from START to STOP

## Operation

- Input conditioning: scl and sda each pass through a 2-flop synchronizer, then a GLITCH_CYC filter.
  - Edge flags come from the filtered levels: scl_rise, scl_fall, sda_rise, sda_fall.
- START is sda_fall while filtered SCL is high. STOP is sda_rise while filtered SCL is high.
- Sampling and driving:
  - SDA is sampled at scl_rise.
  - The slave changes its SDA drive only at scl_fall.
- Bytes are transferred MSB first. A bit counter runs 0..8; count 8 is the ACK clock.
- States:
  - IDLE: wait for START.
  - DEV: shift the address byte in. On a match with DEV_ADDR, go to ACK_DEV; on a mismatch, go to IGNORE.
  - ACK_DEV: pull SDA low for the 9th clock. If R/W=0, go to WORD. If R/W=1, go to RD.
  - WORD: shift in the word address and load the pointer. Go to ACK_WORD.
  - ACK_WORD: ACK, then go to WR.
  - WR: shift in the data byte. At the 8th scl_rise, pulse wr_en with wr_addr = pointer and wr_data = byte, then increment the pointer. Go to ACK_WR.
  - ACK_WR: ACK, then return to WR.
  - RD: shift out the data byte, then go to MACK.
  - MACK: sample the master's ACK at scl_rise. SDA=0 returns to RD. SDA=1 (NACK) goes to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Read prefetch:
  - rd_req pulses at the 9th scl_rise of ACK_DEV (read) and at a MACK scl_rise that samples SDA=0.
  - rd_addr equals the pointer.
  - rd_data is captured into the shift register the next cycle, and the pointer increments in that same cycle.
  - Bit 7 is driven at the following scl_fall.
- The pointer is 8 bits: 0xFF+1 wraps to 0x00. The pointer is retained across transactions.
- Sending a 1 bit means releasing SDA (Z). Sending ACK or a 0 bit means driving 0.

## Timing

- Filter delay: 2 + GLITCH_CYC cycles from a pad edge to its edge flag.
  - Each SCL high or low phase must be at least GLITCH_CYC+4 cycles.
- ACK drive: starts at the scl_fall after the 8th bit, released at the scl_fall after the 9th clock.
- wr_en: exactly 1 cycle, in the cycle after the 8th-bit scl_rise flag.
- rd_req: exactly 1 cycle. rd_data must be valid in the next cycle.
- START in any state, including repeated START: release SDA, clear the bit counter, go to DEV. The pointer is kept.
- STOP in any state: release SDA, go to IDLE, busy=0. A partial byte is discarded and no wr_en is issued.
- If START and scl_fall coincide, START wins.
- Reset values: sda=Z (drive enable 0), wr_en=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, busy=0, pointer=0, state IDLE.
  - Reset asserted mid-transfer releases SDA asynchronously.

## Structure

- Package iic_pkg:
  - state enumeration.
  - ACK=1'b0, NACK=1'b1.
  - RW_BIT=0.
  - BYTE_BITS=8.
- Sub-module iic_line_filter: synchronizer, glitch filter and rise/fall flags. Instantiated once for scl and once for sda.

## Test plan

- Single write, bus-functional master: START, 0xA0, 0x12, 0x5A, STOP -> SDA low on all three 9th clocks; one wr_en with wr_addr=0x12, wr_data=0x5A; busy back to 0 after STOP.
- Burst write with wrap: 0xA0, 0xFF, 0x11, 0x22 -> wr_en pairs (0xFF,0x11) then (0x00,0x22).
- Random read: 0xA0, 0x34, Sr, 0xA1; model returns 0xC3 at 0x34 and 0x3C at 0x35; master ACKs byte 1 and NACKs byte 2 -> SDA carries C3 then 3C; rd_req twice, rd_addr 0x34 then 0x35; no third rd_req; SDA Z after NACK.
- Address mismatch: 0xA2, 0x00 -> SDA Z on every 9th clock; no wr_en or rd_req; IDLE after STOP.
- Glitch and abort:
  - 2-cycle SDA low pulse while SCL high in IDLE -> no START, busy stays 0.
  - STOP after 4 data bits -> no wr_en.
- Reset mid-read while driving 0 -> SDA Z immediately; all outputs at reset values.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C target block.
package iic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_DEV,
    ST_WORD,
    ST_ACK_WORD,
    ST_WR,
    ST_ACK_WR,
    ST_RD,
    ST_MACK,
    ST_IGNORE
  } iic_state_t;

  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;
  localparam int   RW_BIT    = 0;
  localparam int   BYTE_BITS = 8;

  // Bit counter values: last data bit of a byte, and the ACK clock.
  localparam logic [3:0] LAST_BIT = 4'(BYTE_BITS - 1);
  localparam logic [3:0] ACK_CNT  = 4'(BYTE_BITS);

endpackage

// File: rtl/iic_line_filter.sv
// Two-flop synchronizer plus glitch filter for one I2C line, with edge flags.
// The filtered level moves only after GLITCH_CYC consecutive agreeing samples.
module iic_line_filter #(
  parameter int GLITCH_CYC = 3
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int                CNT_W    = (GLITCH_CYC > 2) ? $clog2(GLITCH_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(GLITCH_CYC - 1);

  logic [1:0]       r_sync;
  logic             r_filt;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;

  // Lines idle high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_filt <= 1'b1;
      r_prev <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_pad};
      r_prev <= r_filt;
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_filt;
  assign o_rise  = r_filt & ~r_prev;
  assign o_fall  = ~r_filt & r_prev;

endmodule

// File: rtl/iic_slave.sv
// I2C target: decodes START/STOP, device/word address and data, ACKs on the bus,
// and drives a one-cycle write strobe and a prefetching read port to the register file.
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         GLITCH_CYC = 3
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte;

  iic_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_ptr, w_ptr_nxt;
  logic       r_sda_oe, w_oe_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_wr_en, w_wr_en_nxt;
  logic [7:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic       r_rd_req, w_rd_req_nxt;
  logic [7:0] r_rd_addr, w_rd_addr_nxt;
  logic       r_rd_pend;

  iic_line_filter #(.GLITCH_CYC(GLITCH_CYC)) u_scl_filt (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_pad   (scl),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  iic_line_filter #(.GLITCH_CYC(GLITCH_CYC)) u_sda_filt (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_pad   (sda),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;
  assign w_byte  = {r_shift[6:0], w_sda_lvl};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_ptr_nxt     = r_ptr;
    w_oe_nxt      = r_sda_oe;
    w_rw_nxt      = r_rw;
    w_busy_nxt    = r_busy;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_rd_req_nxt  = 1'b0;
    w_rd_addr_nxt = r_rd_addr;

    // Prefetched byte lands long before the scl_fall that drives its MSB.
    if (r_rd_pend) begin
      w_shift_nxt = rd_data;
      w_ptr_nxt   = r_ptr + 8'd1;
    end

    if (w_start) begin
      w_state_nxt = ST_DEV;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b1;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_DEV, ST_WORD, ST_WR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == LAST_BIT) begin
              w_cnt_nxt = ACK_CNT;
              case (r_state)
                ST_DEV: begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    w_state_nxt = ST_ACK_DEV;
                    w_rw_nxt    = w_byte[RW_BIT];
                  end else begin
                    w_state_nxt = ST_IGNORE;
                  end
                end
                ST_WORD: begin
                  w_ptr_nxt   = w_byte;
                  w_state_nxt = ST_ACK_WORD;
                end
                default: begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = r_ptr;
                  w_wr_data_nxt = w_byte;
                  w_ptr_nxt     = r_ptr + 8'd1;
                  w_state_nxt   = ST_ACK_WR;
                end
              endcase
            end
          end
        end

        // Ninth clock: drive (or release for MACK) at fall, act at rise, leave at next fall.
        ST_ACK_DEV, ST_ACK_WORD, ST_ACK_WR, ST_MACK: begin
          if (w_scl_fall && r_cnt == ACK_CNT) begin
            w_oe_nxt = (r_state != ST_MACK);
          end else if (w_scl_rise && r_cnt == ACK_CNT) begin
            w_cnt_nxt = '0;
            if ((r_state == ST_ACK_DEV && r_rw) ||
                (r_state == ST_MACK && w_sda_lvl == ACK)) begin
              w_rd_req_nxt  = 1'b1;
              w_rd_addr_nxt = r_ptr;
            end
            if (r_state == ST_MACK && w_sda_lvl == NACK) begin
              w_state_nxt = ST_IGNORE;
            end
          end else if (w_scl_fall && r_cnt == 4'd0) begin
            w_oe_nxt = 1'b0;
            case (r_state)
              ST_ACK_DEV: begin
                if (r_rw) begin
                  w_state_nxt = ST_RD;
                  w_oe_nxt    = ~r_shift[7];
                end else begin
                  w_state_nxt = ST_WORD;
                end
              end
              ST_MACK: begin
                w_state_nxt = ST_RD;
                w_oe_nxt    = ~r_shift[7];
              end
              default: w_state_nxt = ST_WR;
            endcase
          end
        end

        ST_RD: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == LAST_BIT) begin
              w_cnt_nxt   = ACK_CNT;
              w_state_nxt = ST_MACK;
            end
          end else if (w_scl_fall && r_cnt != 4'd0) begin
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_oe_nxt    = ~r_shift[6];
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_rw      <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_req  <= 1'b0;
      r_rd_addr <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sda_oe  <= w_oe_nxt;
      r_rw      <= w_rw_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_rd_req  <= w_rd_req_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_rd_pend <= r_rd_req;
    end
  end

  assign sda     = r_sda_oe ? 1'b0 : 1'bz;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_req  = r_rd_req;
  assign rd_addr = r_rd_addr;
  assign busy    = r_busy;

endmodule
